// File: rtl/box_pkg.sv
// Shared constants, request record and FSM encoding for the box drawer.
package box_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;

   localparam logic [COLOUR_W-1:0] COLOUR_WHITE = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DRAW = 1'b1
   } box_state_e;

   typedef struct packed {
      logic [X_W-1:0]      x;
      logic [Y_W-1:0]      y;
      logic [COLOUR_W-1:0] colour;
   } box_req_t;

endpackage

// File: rtl/box_fifo.sv
// Synchronous request FIFO with registered occupancy count and full/empty flags.
// Push and pop on the same edge both take effect; out-of-range operations are ignored.
module box_fifo
   import box_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  box_req_t wdata,
   input  logic     pop,
   output box_req_t rdata,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   box_req_t      mem_q [DEPTH];
   box_req_t      mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          push_ok, pop_ok;

   assign push_ok = push & ~full_q;
   assign pop_ok  = pop & ~empty_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign full    = full_q;
   assign empty   = empty_q;

   // Write the incoming request into the slot at the write pointer.
   always_comb begin
      mem_d = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
      end
   end

   // Advance pointers and occupancy; flags are derived from the next count so they stay registered.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_FULL);
      empty_d = (count_d == '0);
   end

   // Storage array, no reset needed for payload.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Control state with asynchronous reset to empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

endmodule

// File: rtl/box_drawer.sv
// Box drawer: buffers box requests and rasterises each as a BOX_W x BOX_H
// filled rectangle, one registered pixel per cycle, clipping off-screen pixels.
module box_drawer
   import box_pkg::*;
#(
   parameter int BOX_W      = 5,
   parameter int BOX_H      = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [X_W-1:0]      in_x,
   input  logic [Y_W-1:0]      in_y,
   input  logic [COLOUR_W-1:0] in_colour,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                plot,
   output logic                busy,
   output logic                box_done
);

   localparam logic [X_W-1:0] DX_LAST = X_W'(BOX_W - 1);
   localparam logic [Y_W-1:0] DY_LAST = Y_W'(BOX_H - 1);
   localparam logic [X_W:0]   X_MAX   = (X_W + 1)'(SCREEN_W - 1);
   localparam logic [Y_W:0]   Y_MAX   = (Y_W + 1)'(SCREEN_H - 1);

   box_state_e          state_q, state_d;
   box_req_t            req_q, req_d;
   logic [X_W-1:0]      dx_q, dx_d;
   logic [Y_W-1:0]      dy_q, dy_d;
   logic [X_W-1:0]      vga_x_q, vga_x_d;
   logic [Y_W-1:0]      vga_y_q, vga_y_d;
   logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
   logic                plot_q, plot_d;
   logic                last_q, last_d;
   logic                box_done_q, box_done_d;
   logic                live_q, live_d;

   logic                push, pop;
   logic                fifo_full, fifo_empty;
   box_req_t            wdata, head;
   logic [X_W:0]        sum_x;
   logic [Y_W:0]        sum_y;
   logic                on_screen;

   assign in_ready = live_q & ~fifo_full;
   assign push     = in_valid & in_ready;
   assign wdata    = '{x: in_x, y: in_y, colour: in_colour};

   box_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (resetn),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Pixel coordinates carry one extra bit so right/bottom overflow is detectable.
   assign sum_x     = {1'b0, req_q.x} + {1'b0, dx_q};
   assign sum_y     = {1'b0, req_q.y} + {1'b0, dy_q};
   assign on_screen = (sum_x <= X_MAX) && (sum_y <= Y_MAX);

   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign plot       = plot_q;
   assign box_done   = box_done_q;
   assign busy       = ~fifo_empty | (state_q == ST_DRAW) | last_q;

   // Leaving reset: in_ready is held low until the first edge after release.
   always_comb begin
      live_d = 1'b1;
   end

   // Scan FSM: pop a request, sweep dx fastest then dy, chain straight into the next box.
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      dx_d         = dx_q;
      dy_d         = dy_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      plot_d       = 1'b0;
      last_d       = 1'b0;
      pop          = 1'b0;
      box_done_d   = last_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               req_d   = head;
               dx_d    = '0;
               dy_d    = '0;
               state_d = ST_DRAW;
            end
         end
         ST_DRAW: begin
            vga_x_d      = sum_x[X_W-1:0];
            vga_y_d      = sum_y[Y_W-1:0];
            vga_colour_d = req_q.colour;
            plot_d       = on_screen;
            if (dx_q == DX_LAST) begin
               dx_d = '0;
               if (dy_q == DY_LAST) begin
                  dy_d   = '0;
                  last_d = 1'b1;
                  if (!fifo_empty) begin
                     pop   = 1'b1;
                     req_d = head;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  dy_d = dy_q + Y_W'(1);
               end
            end else begin
               dx_d = dx_q + X_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Current box payload, loaded on every pop.
   always_ff @(posedge clk) begin
      req_q <= req_d;
   end

   // Control, counters and registered VGA outputs, cleared by asynchronous reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         dx_q         <= '0;
         dy_q         <= '0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         plot_q       <= 1'b0;
         last_q       <= 1'b0;
         box_done_q   <= 1'b0;
         live_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         dx_q         <= dx_d;
         dy_q         <= dy_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         plot_q       <= plot_d;
         last_q       <= last_d;
         box_done_q   <= box_done_d;
         live_q       <= live_d;
      end
   end

endmodule

// File: tb/tb_box_drawer.sv
// Bench for box_drawer: timeline reference model (box start/end edges derived
// from acceptance times), a table of single-box vectors, and directed sequences.
module tb_box_drawer;

   localparam int BW    = 5;
   localparam int BH    = 3;
   localparam int DEPTH = 4;

   logic       clk;
   logic       resetn;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_x;
   logic [6:0] in_y;
   logic [2:0] in_colour;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       plot;
   logic       busy;
   logic       box_done;

   box_drawer #(
      .BOX_W      (BW),
      .BOX_H      (BH),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_colour  (in_colour),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .plot       (plot),
      .busy       (busy),
      .box_done   (box_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: edges counted since reset release; per box its accept edge,
   // first-pixel output edge and last-pixel output edge.
   int n;
   int t_q[$];
   int s_q[$];
   int e_q[$];
   int bx_q[$];
   int by_q[$];
   int bc_q[$];
   bit exp_ready;
   bit e_plot, e_busy, e_done;
   logic [7:0] hx;
   logic [6:0] hy;
   logic [2:0] hc;

   // Observed tallies for directed checks.
   int plot_cnt, done_cnt, min_x, max_x, min_y, max_y, first_plot, last_plot;

   function automatic void chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, n);
      end
   endfunction

   function automatic void model_clear();
      t_q.delete(); s_q.delete(); e_q.delete();
      bx_q.delete(); by_q.delete(); bc_q.delete();
      n = 0;
      exp_ready = 1'b0;
      e_plot = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      hx = '0; hy = '0; hc = '0;
   endfunction

   function automatic void model_accept(int x, int y, int c);
      int s, prev_end;
      prev_end = (e_q.size() > 0) ? e_q[e_q.size()-1] : -100;
      s = (n + 2 > prev_end + 1) ? n + 2 : prev_end + 1;
      t_q.push_back(n);
      s_q.push_back(s);
      e_q.push_back(s + BW * BH - 1);
      bx_q.push_back(x);
      by_q.push_back(y);
      bc_q.push_back(c);
   endfunction

   function automatic void model_eval();
      int occ;
      occ = 0;
      e_plot = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      for (int k = 0; k < t_q.size(); k++) begin
         if (t_q[k] <= n) occ++;
         if (s_q[k] - 1 <= n) occ--;
         if (n >= s_q[k] - 1 && n <= e_q[k]) e_busy = 1'b1;
         if (n == e_q[k] + 1) e_done = 1'b1;
         if (n >= s_q[k] && n <= e_q[k]) begin
            int i, px, py;
            i  = n - s_q[k];
            px = bx_q[k] + i % BW;
            py = by_q[k] + i / BW;
            e_plot = (px < 160) && (py < 120);
            hx = 8'(px);
            hy = 7'(py);
            hc = 3'(bc_q[k]);
         end
      end
      if (occ > 0) e_busy = 1'b1;
      exp_ready = (n >= 1) && (occ < DEPTH);
   endfunction

   function automatic void check_outputs();
      logic [21:0] act, req;
      act = {in_ready, plot, busy, box_done, vga_x, vga_y, vga_colour};
      req = {exp_ready, e_plot, e_busy, e_done, hx, hy, hc};
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL cycle edge %0d: got rdy=%b plot=%b busy=%b done=%b x=%0d y=%0d c=%0d, expected rdy=%b plot=%b busy=%b done=%b x=%0d y=%0d c=%0d",
                  n, in_ready, plot, busy, box_done, vga_x, vga_y, vga_colour,
                  exp_ready, e_plot, e_busy, e_done, hx, hy, hc);
      end
   endfunction

   function automatic void check_zero(string name);
      logic [21:0] act;
      act = {in_ready, plot, busy, box_done, vga_x, vga_y, vga_colour};
      chk(name, int'(act), 0);
   endfunction

   function automatic void tally_clear();
      plot_cnt = 0; done_cnt = 0;
      min_x = 999; max_x = -1; min_y = 999; max_y = -1;
      first_plot = -1; last_plot = -1;
   endfunction

   // One clock: drive inputs, advance model at the edge, compare on the falling edge.
   task automatic step(input bit v, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      bit acc;
      in_valid  = v;
      in_x      = x;
      in_y      = y;
      in_colour = c;
      acc = v && exp_ready;
      @(posedge clk);
      n++;
      if (acc) model_accept(int'(x), int'(y), int'(c));
      model_eval();
      @(negedge clk);
      check_outputs();
      if (plot) begin
         plot_cnt++;
         if (int'(vga_x) < min_x) min_x = int'(vga_x);
         if (int'(vga_x) > max_x) max_x = int'(vga_x);
         if (int'(vga_y) < min_y) min_y = int'(vga_y);
         if (int'(vga_y) > max_y) max_y = int'(vga_y);
         if (first_plot < 0) first_plot = n;
         last_plot = n;
      end
      if (box_done) done_cnt++;
   endtask

   task automatic step_idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 8'd0, 7'd0, 3'd0);
   endtask

   // Asynchronous reset applied mid low-phase; outputs must clear immediately.
   task automatic apply_reset(input string name);
      in_valid = 1'b0;
      #2 resetn = 1'b0;
      #1 check_zero({name, "_async"});
      @(negedge clk);
      check_zero({name, "_hold"});
      resetn = 1'b1;
      model_clear();
   endtask

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      int         plots;
      int         minx, maxx, miny, maxy;
   } vec_t;

   vec_t vecs[6];

   initial begin : main
      int idx;
      logic [7:0] rx;
      logic [6:0] ry;

      vecs[0] = '{8'd38,  7'd4,   box_pkg::COLOUR_WHITE, 15, 38,  42,  4,   6};
      vecs[1] = '{8'd158, 7'd118, 3'b010,                 4, 158, 159, 118, 119};
      vecs[2] = '{8'd0,   7'd0,   3'b001,                15, 0,   4,   0,   2};
      vecs[3] = '{8'd159, 7'd119, 3'b101,                 1, 159, 159, 119, 119};
      vecs[4] = '{8'd157, 7'd0,   3'b011,                 9, 157, 159, 0,   2};
      vecs[5] = '{8'd10,  7'd118, 3'b100,                10, 10,  14,  118, 119};

      resetn = 1'b0;
      in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
      model_clear();
      @(negedge clk);
      apply_reset("reset_init");
      step_idle(1);

      // Single boxes from idle: coverage, clipping and one done pulse each.
      for (int v = 0; v < 6; v++) begin
         tally_clear();
         step(1'b1, vecs[v].x, vecs[v].y, vecs[v].c);
         step_idle(20);
         chk($sformatf("vec%0d_plots", v), plot_cnt, vecs[v].plots);
         chk($sformatf("vec%0d_minx", v), min_x, vecs[v].minx);
         chk($sformatf("vec%0d_maxx", v), max_x, vecs[v].maxx);
         chk($sformatf("vec%0d_miny", v), min_y, vecs[v].miny);
         chk($sformatf("vec%0d_maxy", v), max_y, vecs[v].maxy);
         chk($sformatf("vec%0d_done", v), done_cnt, 1);
      end

      // Five back-to-back requests: FIFO fills, then 75 gap-free plot cycles.
      apply_reset("reset_b2b");
      step_idle(1);
      tally_clear();
      for (int i = 0; i < 5; i++) step(1'b1, 8'(20 + i * 10), 7'(30 + i), 3'(i + 1));
      chk("b2b_ready_full", int'(in_ready), 0);
      for (int k = 0; k < 100 && done_cnt < 5; k++) step_idle(1);
      chk("b2b_plots", plot_cnt, 75);
      chk("b2b_contiguous", last_plot - first_plot + 1, 75);
      chk("b2b_done", done_cnt, 5);

      // Push coinciding with a pop while two entries are stored.
      apply_reset("reset_pp");
      step_idle(1);
      step(1'b1, 8'd50, 7'd50, 3'd1);
      step(1'b1, 8'd60, 7'd60, 3'd2);
      step(1'b1, 8'd70, 7'd70, 3'd3);
      idx = s_q.size() - 2;
      for (int k = 0; k < 40 && (n + 1) != s_q[idx] - 1; k++) step_idle(1);
      chk("pp_align", n + 1, s_q[idx] - 1);
      step(1'b1, 8'd80, 7'd80, 3'd4);
      chk("pp_occupancy", int'(dut.u_fifo.count_q), 2);
      chk("pp_ready", int'(in_ready), 1);
      step_idle(60);

      // Reset at pixel 7 with two requests queued: everything abandoned.
      apply_reset("reset_mid_pre");
      step_idle(1);
      step(1'b1, 8'd30, 7'd30, 3'd6);
      step(1'b1, 8'd40, 7'd40, 3'd5);
      step(1'b1, 8'd50, 7'd40, 3'd4);
      idx = s_q.size() - 3;
      for (int k = 0; k < 40 && n != s_q[idx] + 7; k++) step_idle(1);
      chk("mid_pixel7_plot", int'(plot), 1);
      apply_reset("reset_mid");
      tally_clear();
      step_idle(30);
      chk("mid_no_plots", plot_cnt, 0);
      chk("mid_busy", int'(busy), 0);

      // Random traffic with edge-biased coordinates against the timeline model.
      apply_reset("reset_rand");
      for (int i = 0; i < 400; i++) begin
         rx = ($urandom_range(0, 9) < 3) ? 8'($urandom_range(150, 159)) : 8'($urandom_range(0, 159));
         ry = ($urandom_range(0, 9) < 3) ? 7'($urandom_range(110, 119)) : 7'($urandom_range(0, 119));
         step($urandom_range(0, 3) == 0, rx, ry, 3'($urandom_range(0, 7)));
      end
      step_idle(80);
      chk("rand_drained_busy", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/box_drawer.md
BOX_DRAWER -- requirements
Module: box_drawer

Interface
REQ-001 The block SHALL have parameter BOX_W, default 5, giving box width in pixels.
REQ-002 The block SHALL have parameter BOX_H, default 3, giving box height in pixels.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving request buffer entries (power of two).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a box request is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: a request can be accepted.
REQ-008 The block SHALL have port in_x, input, 8 bits: box top-left x (0..159).
REQ-009 The block SHALL have port in_y, input, 7 bits: box top-left y (0..119).
REQ-010 The block SHALL have port in_colour, input, 3 bits: box fill colour, RGB.
REQ-011 The block SHALL have port vga_x, output, 8 bits: pixel x to the VGA adapter.
REQ-012 The block SHALL have port vga_y, output, 7 bits: pixel y to the VGA adapter.
REQ-013 The block SHALL have port vga_colour, output, 3 bits: pixel colour.
REQ-014 The block SHALL have port plot, output, 1 bit: write-enable to the VGA adapter.
REQ-015 The block SHALL have port busy, output, 1 bit: the FIFO is non-empty or a box is being drawn.
REQ-016 The block SHALL have port box_done, output, 1 bit: one-cycle pulse when a box has finished.

Function
REQ-017 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL equal not-full of the request FIFO.
REQ-018 Accepted requests SHALL be drawn in arrival order, with {x,y,colour} stored unchanged.
REQ-019 The FSM SHALL have states IDLE and DRAW; IDLE->DRAW on an edge where the FIFO is non-empty, popping the head entry.
REQ-020 In DRAW, one pixel SHALL be emitted per cycle, with dx incrementing fastest over 0..BOX_W-1, then dy over 0..BOX_H-1.
REQ-021 Each pixel SHALL output vga_x=x+dx and vga_y=y+dy, computed at 9 and 8 bits, and vga_colour=colour; all outputs SHALL be registered.
REQ-022 plot SHALL be 0 for any pixel with x+dx>159 or y+dy>119 (clipping), and the counters SHALL still advance.
REQ-023 For a request accepted at edge t with the block idle, pixel (0,0) SHALL appear with plot=1 in the cycle after edge t+2.
REQ-024 A box SHALL occupy exactly BOX_W*BOX_H consecutive pixel cycles.
REQ-025 On the last pixel, if the FIFO is non-empty the next entry SHALL be popped the same edge, with no bubble; otherwise the FSM SHALL return to IDLE.
REQ-026 box_done SHALL pulse for the one cycle after each box's last pixel cycle.
REQ-027 A push and a pop on the same edge SHALL both take effect, leaving occupancy unchanged.
REQ-028 When the FIFO is full, in_ready=0 and in_valid SHALL be ignored, even on the same edge as a pop.
REQ-029 In IDLE, plot SHALL be 0 and vga_x, vga_y and vga_colour SHALL hold their last values.

Reset
REQ-030 While resetn=0, in_ready, plot, busy and box_done SHALL be 0; vga_x, vga_y and vga_colour SHALL be 0; the FIFO SHALL be empty; and the FSM SHALL be in IDLE.
REQ-031 Reset asserted mid-box SHALL abandon the box and all buffered requests immediately, with no further plot.
REQ-032 in_ready SHALL rise on the first edge after resetn deasserts.

Structure
REQ-033 Shared package box_pkg SHALL hold SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOUR_W=3, COLOUR_WHITE=3'b111 and the FSM state encoding.
REQ-034 The request buffer SHALL be a sub-module box_fifo: a synchronous FIFO with registered occupancy count and full/empty flags.

Verification
REQ-035 A single request (38,4,111) SHALL produce 15 plot cycles covering x 38..42 and y 4..6, row-major, followed by one box_done pulse.
REQ-036 Five back-to-back requests pushed on consecutive cycles SHALL give in_ready=0 after the 4th is held, and 75 contiguous plot cycles with no gaps.
REQ-037 A request (158,118,010) SHALL give plot=1 only at (158,118), (159,118), (158,119) and (159,119), with the box lasting 15 cycles.
REQ-038 resetn pulled low at pixel 7 of a box with 2 queued requests SHALL give plot=0 at once, and after release busy=0 with no further pixels.
REQ-039 A push and a pop on the same edge with 2 entries stored SHALL leave occupancy at 2 and in_ready=1.
